layer_4_conv_sequencer: RTL and testbench
=========================================

# layer_4_conv_sequencer

Frame sequencer for one layer-4 feature-map convolution bank. It walks a zero-padded IMG_SIZE×IMG_SIZE input frame in raster order and fetches unpadded pixels from the feature-map buffer. It drives the 32-channel packed word and `valid_in` strobe into the Conv2D3x3 bank, then counts the bank's output strobes to signal frame completion. It sits between the layer's input feature-map RAM and the `layer_4_featuremap_*` instances.

## Interface
- `IMG_SIZE`, 104: unpadded frame width and height, in pixels.
- `DATA_WIDTH`, 1024: packed pixel word, 32 channels × 32-bit float.
- `ADDR_WIDTH`, 14: buffer address width; must satisfy 2^ADDR_WIDTH ≥ IMG_SIZE².
- `CNT_WIDTH`, 14: output-counter width; must satisfy 2^CNT_WIDTH > IMG_SIZE².

Ports:
- `Clk` in 1: the single clock.
- `Rst` in 1: asynchronous, active-high reset.
- `start` in 1: frame start request, level-sampled.
- `stall` in 1: downstream backpressure; holds the scan.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out ADDR_WIDTH: buffer address.
- `rd_data` in DATA_WIDTH: buffer data, valid exactly 1 cycle after `rd_en`.
- `conv_data` out DATA_WIDTH: pixel word to the bank (`data_in`).
- `conv_valid` out 1: strobe to the bank (`valid_in`).
- `conv_valid_out` in 1: output strobe from the bank (`valid_out`).
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: 1-cycle pulse when the frame is complete.
- `out_count` out CNT_WIDTH: number of `conv_valid_out` strobes in the current frame.

## Operation
- **States:** IDLE, STREAM, DRAIN, DONE. Encoding is free.
- **IDLE:**
  - `start`=1 at a clock edge clears `row`, `col` and `out_count`, then enters STREAM.
  - `start` is ignored in every state other than IDLE.
- **STREAM (scan):**
  - The scan covers the padded frame P=IMG_SIZE+2. Counters run `row`,`col` ∈ [0,P-1], with `col` incrementing fastest.
  - One position is issued per cycle when `stall`=0. When `stall`=1, the counters hold and nothing is issued.
- **STREAM (position types):**
  - Interior position (1≤row≤IMG_SIZE and 1≤col≤IMG_SIZE): assert `rd_en` with `rd_addr`=(row-1)·IMG_SIZE+(col-1). The address is computed with a running address register, not a multiplier.
  - Border position: `rd_en`=0, and the position is marked as a zero pixel.
- **STREAM (exit):** issuing position (P-1,P-1) enters DRAIN.
- **Emit stage (registered, 1 cycle after issue):**
  - `conv_valid`=1 for every issued position.
  - `conv_data`=`rd_data` if the position was interior, otherwise all zeros.
  - `conv_valid`=0 in every cycle after a non-issue.
- **Output counting:**
  - `out_count` increments on each `conv_valid_out`=1 while in STREAM or DRAIN, saturating at IMG_SIZE².
  - `conv_valid_out` in IDLE or DONE is ignored.
- **DRAIN:** remains until `out_count`=IMG_SIZE², then enters DONE. This also covers the case where the count is reached on the same edge as the last issue.
- **DONE:** asserts `done` for exactly 1 cycle, then unconditionally returns to IDLE. `out_count` holds its final value until the next accepted `start`.
- **Frame totals:** exactly P² `conv_valid` pulses and exactly IMG_SIZE² `rd_en` pulses per frame.

## Timing
- **Reset:** asynchronous. While `Rst`=1:
  - State is IDLE.
  - `rd_en`=0, `rd_addr`=0, `conv_valid`=0, `conv_data`=0, `busy`=0, `done`=0, `out_count`=0.
- **Mid-frame reset:** abandons the frame with no `done` pulse. The in-flight emit is dropped.
- **Start latency:** `start` sampled at edge k gives `busy`=1 after k. The first issue happens in cycle k→k+1, and the first `conv_valid` is seen after edge k+1.
- **Stall:** `stall` sampled at edge e suppresses the issue in cycle e. Its effect reaches `conv_valid` one cycle later; the emit already in flight still completes.
- **No-stall throughput:** P² consecutive `conv_valid` cycles.
- **Outputs:** `rd_en` and `rd_addr` are registered outputs.
- **Done timing:** `done` is high in the cycle after the edge at which the final count is reached. `busy` falls together with `done` falling.

## Test plan
- **Basic frame (IMG_SIZE=4, no stall, bank model asserts `conv_valid_out` on each pixel with fixed latency):**
  - 36 consecutive `conv_valid` pulses and 16 `rd_en` pulses.
  - `rd_addr` sequence 0..15.
  - Zeros on rows 0 and 5 and on cols 0 and 5.
  - `done` after the 16th `conv_valid_out`; `out_count`=16.
- **Start latency:** `start` sampled at edge 10 → `rd_en`=0 with `rd_addr` held (border) after edge 10; first `conv_valid` after edge 11.
- **Backpressure:** `stall`=1 for 3 cycles at the 8th issue → gap of exactly 3 in `conv_valid`, data order unchanged, totals still 36/16.
- **Drain:**
  - Bank model delays `conv_valid_out` by 50 cycles → state stays DRAIN until count 16, `busy`=1 throughout.
  - `start` pulses during DRAIN are ignored.
- **Reset mid-frame:** `Rst` asserted at the 20th issue → all outputs 0 immediately with no `done`. A new `start` restarts at `rd_addr`=0 and `out_count`=0.
- **Spurious strobe:** `conv_valid_out`=1 in IDLE → `out_count` stays 0 and `done` stays 0.

Source files
------------

// File: rtl/layer_4_conv_sequencer.sv
// Raster-scans a zero-padded frame, reading interior pixels and emitting one word per issued position
// (emit 1 cycle after issue); stall holds the scan, and done pulses once all bank outputs are counted.
module layer_4_conv_sequencer #(
    parameter int IMG_SIZE   = 104,
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 14,
    parameter int CNT_WIDTH  = 14
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic                  stall,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] conv_data,
    output logic                  conv_valid,
    input  logic                  conv_valid_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  out_count
);
    localparam int P    = IMG_SIZE + 2;
    localparam int RC_W = $clog2(P + 1);
    localparam logic [RC_W-1:0]      LAST   = RC_W'(P - 1);
    localparam logic [RC_W-1:0]      IMG_HI = RC_W'(IMG_SIZE);
    localparam logic [CNT_WIDTH-1:0] TOTAL  = CNT_WIDTH'(IMG_SIZE * IMG_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [RC_W-1:0]       row, col;
    logic [RC_W-1:0]       pos_row, pos_col;
    logic [ADDR_WIDTH-1:0] addr_run;
    logic                  start_acc;
    logic                  issue;
    logic                  interior;
    logic                  last_pos;
    logic                  count_inc;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  pres_vld;
    logic                  emit_int;

    // row/col name the next position to issue; the accepting start edge issues (0,0) itself.
    always_comb begin
        start_acc = (state == S_IDLE) && start;
        pos_row   = (state == S_IDLE) ? '0 : row;
        pos_col   = (state == S_IDLE) ? '0 : col;
        issue     = !stall && (start_acc || (state == S_STREAM));
        interior  = (pos_row != '0) && (pos_row <= IMG_HI) &&
                    (pos_col != '0) && (pos_col <= IMG_HI);
        last_pos  = (pos_row == LAST) && (pos_col == LAST);
        count_inc = conv_valid_out && (out_count != TOTAL) &&
                    ((state == S_STREAM) || (state == S_DRAIN));
        count_nxt = out_count + {{(CNT_WIDTH-1){1'b0}}, count_inc};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (issue && last_pos) begin
                    state_nxt = (count_nxt == TOTAL) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_nxt == TOTAL) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            row        <= '0;
            col        <= '0;
            addr_run   <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            pres_vld   <= 1'b0;
            conv_valid <= 1'b0;
            emit_int   <= 1'b0;
            out_count  <= '0;
        end else begin
            rd_en      <= issue && interior;
            pres_vld   <= issue;
            conv_valid <= pres_vld;
            emit_int   <= rd_en;

            // Interior addresses are consecutive in raster order, so a running counter suffices.
            if (issue && interior) begin
                rd_addr  <= addr_run;
                addr_run <= addr_run + ADDR_WIDTH'(1);
            end else if (start_acc) begin
                addr_run <= '0;
            end

            if (issue) begin
                if (pos_col == LAST) begin
                    col <= '0;
                    row <= pos_row + RC_W'(1);
                end else begin
                    col <= pos_col + RC_W'(1);
                    row <= pos_row;
                end
            end else if (start_acc) begin
                row <= '0;
                col <= '0;
            end

            if (start_acc) begin
                out_count <= '0;
            end else begin
                out_count <= count_nxt;
            end
        end
    end

    // rd_data arrives the cycle after rd_en, which is exactly when the matching emit is live.
    assign conv_data = (conv_valid && emit_int) ? rd_data : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_layer_4_conv_sequencer.sv
module tb_layer_4_conv_sequencer;
    localparam int N  = 4;
    localparam int P  = N + 2;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int CW = 5;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          start;
    logic          stall;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] conv_data;
    logic          conv_valid;
    logic          conv_valid_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] out_count;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    string         frame_name;
    logic [DW-1:0] mem [N*N];
    int            bank_q[$];
    logic [DW-1:0] exp_words[$];
    bit            exp_int[$];
    int            exp_addrs[$];
    int            strobes;
    int            last_strobe;
    int            exp_count;
    bit            spurious;
    logic          prev_rd_en;
    logic [AW-1:0] prev_addr;

    layer_4_conv_sequencer #(
        .IMG_SIZE  (N),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .start         (start),
        .stall         (stall),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .conv_data     (conv_data),
        .conv_valid    (conv_valid),
        .conv_valid_out(conv_valid_out),
        .busy          (busy),
        .done          (done),
        .out_count     (out_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", frame_name, tag, obs, exp);
        end
    endtask

    // One clock: feed the buffer read and bank strobe for the new cycle, then let outputs settle.
    task automatic step();
        @(posedge Clk);
        cyc++;
        #1;
        rd_data = prev_rd_en ? mem[prev_addr] : DW'($urandom);
        exp_count = strobes;
        conv_valid_out = spurious;
        if (bank_q.size() > 0 && bank_q[0] == cyc) begin
            void'(bank_q.pop_front());
            conv_valid_out = 1'b1;
            strobes++;
            if (strobes == N*N) last_strobe = cyc;
        end
        #1;
        prev_rd_en = rd_en;
        prev_addr  = rd_addr;
    endtask

    task automatic run_frame(input string name, input int lat, input int stall_at,
                             input int stall_len, input int rst_at, input bit poke);
        int            t;
        int            cv_seen;
        int            rd_seen;
        int            gap;
        int            r;
        int            c;
        bit            done_seen;
        bit            inr;
        logic [DW-1:0] w;
        logic [AW-1:0] pre_addr;

        frame_name = name;
        exp_words.delete();
        exp_int.delete();
        exp_addrs.delete();
        bank_q.delete();
        for (int i = 0; i < N*N; i++) mem[i] = DW'($urandom);
        for (int j = 0; j < P*P; j++) begin
            r = j / P;
            c = j % P;
            if (r >= 1 && r <= N && c >= 1 && c <= N) begin
                exp_words.push_back(mem[(r-1)*N + (c-1)]);
                exp_int.push_back(1'b1);
                exp_addrs.push_back((r-1)*N + (c-1));
            end else begin
                exp_words.push_back('0);
                exp_int.push_back(1'b0);
            end
        end
        strobes = 0;
        last_strobe = -100;
        cv_seen = 0;
        rd_seen = 0;
        gap = 0;
        done_seen = 0;
        pre_addr = rd_addr;

        stall = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_rd_en", rd_en, 0);
        chk("start_addr_held", rd_addr, pre_addr);
        chk("start_conv_valid", conv_valid, 0);

        t = 0;
        while (!done_seen && t < 400) begin
            t++;
            stall = (stall_at >= 0 && t >= stall_at && t < stall_at + stall_len);
            start = poke && (cv_seen == P*P) && (t % 5 == 0);
            step();
            if (t == rst_at) begin
                chk("pre_rst_rd_en", rd_en, 1);
                #1 Rst = 1'b1;
                #1;
                chk("rst_rd_en", rd_en, 0);
                chk("rst_rd_addr", rd_addr, 0);
                chk("rst_conv_valid", conv_valid, 0);
                chk("rst_conv_data", conv_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_out_count", out_count, 0);
                start = 1'b0;
                stall = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("rst_hold_done", done, 0);
                    chk("rst_hold_busy", busy, 0);
                end
                @(negedge Clk);
                Rst = 1'b0;
                bank_q.delete();
                prev_rd_en = 1'b0;
                return;
            end
            if (t == 1) chk("first_conv_valid", conv_valid, 1);
            chk("busy", busy, 1);
            chk("done", done, cyc == last_strobe + 1);
            chk("out_count", out_count, exp_count);
            if (conv_valid) begin
                if (exp_words.size() == 0) begin
                    chk("extra_conv_valid", 1, 0);
                end else begin
                    w   = exp_words.pop_front();
                    inr = exp_int.pop_front();
                    chk("conv_data", conv_data, w);
                    if (inr) bank_q.push_back(cyc + lat);
                end
                cv_seen++;
            end else if (cv_seen > 0 && cv_seen < P*P) begin
                gap++;
            end
            if (rd_en) begin
                if (exp_addrs.size() == 0) chk("extra_rd_en", 1, 0);
                else chk("rd_addr", rd_addr, exp_addrs.pop_front());
                rd_seen++;
            end
            if (done) done_seen = 1'b1;
        end
        start = 1'b0;
        stall = 1'b0;
        if (!done_seen) chk("timeout", 0, 1);
        chk("total_conv_valid", cv_seen, P*P);
        chk("total_rd_en", rd_seen, N*N);
        chk("conv_valid_gap", gap, stall_len);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("held_count", out_count, N*N);
    endtask

    initial begin
        Rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        rd_data = '0;
        conv_valid_out = 1'b0;
        spurious = 1'b0;
        prev_rd_en = 1'b0;
        prev_addr = '0;
        strobes = 0;
        last_strobe = -100;
        exp_count = 0;
        frame_name = "reset";
        #2;
        chk("rd_en", rd_en, 0);
        chk("rd_addr", rd_addr, 0);
        chk("conv_valid", conv_valid, 0);
        chk("conv_data", conv_data, 0);
        chk("busy", busy, 0);
        chk("done", done, 0);
        chk("out_count", out_count, 0);
        @(negedge Clk);
        Rst = 1'b0;

        frame_name = "spurious_idle";
        spurious = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("out_count", out_count, 0);
            chk("done", done, 0);
            chk("busy", busy, 0);
        end
        spurious = 1'b0;
        step();
        chk("out_count_after", out_count, 0);

        run_frame("basic", 10, -1, 0, -1, 1'b0);

        frame_name = "spurious_held";
        spurious = 1'b1;
        step();
        step();
        spurious = 1'b0;
        step();
        chk("out_count", out_count, N*N);
        chk("done", done, 0);

        run_frame("stall", 10, 7, 3, -1, 1'b0);
        run_frame("drain", 50, -1, 0, -1, 1'b1);
        run_frame("mid_reset", 10, -1, 0, 19, 1'b0);
        run_frame("restart", 12, -1, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
